// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch stage.
// Fetches one word per instruction over a req/ready handshake, holds it for
// decode, then computes the next PC from the resolved control inputs.
// Ports: clk, rst_n (async, active-low)
//        imem_req/imem_addr/imem_ready/imem_rdata : instruction memory port
//        instr_valid/instr/pc_out/pc_plus4         : to decode
//        stall, branch_taken/branch_offset, jump/jump_index, jr/jr_target
//        misaligned_err : sticky, set by an unaligned jr target
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        misaligned_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic [31:0] instr_q;
    logic [31:0] instr_nx;
    logic        valid_q;
    logic        valid_nx;
    logic        err_q;
    logic        err_nx;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign pc_plus4   = pc + 32'd4;
    // Offset counts words; bits [31:30] fall off the shift and the add wraps.
    assign br_target  = pc_plus4 + {branch_offset[29:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], jump_index, 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            instr_q <= instr_nx;
            valid_q <= valid_nx;
            err_q   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        instr_nx = instr_q;
        valid_nx = valid_q;
        err_nx   = err_q;
        case (state)
            BOOT: begin
                state_nx = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_nx = imem_rdata;
                    valid_nx = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    valid_nx = 1'b0;
                    state_nx = FETCH;
                    if (jr) begin
                        if (jr_target[1:0] != 2'b00) begin
                            err_nx   = 1'b1;
                            state_nx = HALT;
                        end else begin
                            pc_nx = jr_target;
                        end
                    end else if (jump) begin
                        pc_nx = jmp_target;
                    end else if (branch_taken) begin
                        pc_nx = br_target;
                    end else begin
                        pc_nx = pc_plus4;
                    end
                end
            end
            HALT: begin
                valid_nx = 1'b0;
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    assign imem_req       = (state == FETCH);
    assign imem_addr      = pc;
    assign pc_out         = pc;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign misaligned_err = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: self-checking bench for pc_fetch_unit.
// Expected fetch addresses are queued on each issue and checked on fetch.
module tb_pc_fetch_unit;

    localparam logic [31:0] KEY = 32'h2008_0005;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_target;
    logic        misaligned_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        br;
        logic [31:0] off;
        logic        j;
        logic [25:0] idx;
        logic        r;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[11];

    pc_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc_out         (pc_out),
        .pc_plus4       (pc_plus4),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .jump           (jump),
        .jump_index     (jump_index),
        .jr             (jr),
        .jr_target      (jr_target),
        .misaligned_err (misaligned_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word content derived from its address.
    assign imem_rdata = imem_addr ^ KEY;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic clear_ctrl();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 32'h0;
        jump          = 1'b0;
        jump_index    = 26'h0;
        jr            = 1'b0;
        jr_target     = 32'h0;
    endtask

    // Wait for a fetch (bounded), check address against the scoreboard,
    // then check the captured word after the accepting edge.
    task automatic fetch_one(input string name);
        int n;
        logic [31:0] e;
        n = 0;
        @(negedge clk);
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!imem_req || exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_timeout actual req=%b q=%0d required req=1",
                     name, imem_req, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            chk({name, "_addr"}, imem_addr, e);
            chk({name, "_p4"}, pc_plus4, e + 32'd4);
            @(posedge clk);
            @(negedge clk);
            chk({name, "_valid"}, {31'h0, instr_valid}, 32'h1);
            chk({name, "_instr"}, instr, e ^ KEY);
        end
    endtask

    task automatic issue(input vec_t v);
        branch_taken  = v.br;
        branch_offset = v.off;
        jump          = v.j;
        jump_index    = v.idx;
        jr            = v.r;
        jr_target     = v.tgt;
        exp_q.push_back(v.exp_pc);
        @(posedge clk);
        #1;
        clear_ctrl();
    endtask

    initial begin
        vec_t v;
        logic [31:0] hold_pc;
        logic [31:0] hold_instr;

        vecs[0]  = '{1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0004};
        vecs[1]  = '{1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0008};
        vecs[2]  = '{1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h100, 32'h0000_0100};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0, 32'h0,
                     32'h0000_00FC};
        vecs[4]  = '{1'b1, 32'h0000_7FFF, 1'b0, 26'h0, 1'b0, 32'h0,
                     32'h0002_00FC};
        vecs[5]  = '{1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h3000_0040,
                     32'h3000_0040};
        vecs[6]  = '{1'b1, 32'h0000_0010, 1'b1, 26'h0000100, 1'b0, 32'h0,
                     32'h3000_0400};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 26'h0000100, 1'b1, 32'h0000_0200,
                     32'h0000_0200};
        vecs[8]  = '{1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC,
                     32'hFFFF_FFFC};
        vecs[9]  = '{1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,
                     32'h0FFF_FFFC};

        clear_ctrl();
        imem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err", {31'h0, misaligned_err}, 32'h0);

        // First fetch: request after BOOT, valid two edges after release.
        rst_n = 1'b1;
        exp_q.push_back(32'h0);
        @(negedge clk);
        chk("boot_req", {31'h0, imem_req}, 32'h1);
        chk("boot_valid", {31'h0, instr_valid}, 32'h0);
        chk("boot_addr", imem_addr, exp_q.pop_front());
        @(negedge clk);
        chk("first_valid", {31'h0, instr_valid}, 32'h1);
        chk("first_instr", instr, 32'h2008_0005);
        chk("first_req", {31'h0, imem_req}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i]);
            fetch_one($sformatf("vec%0d", i));
        end

        // Wait states at pc 0x10.
        v = '{1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h10, 32'h10};
        imem_ready = 1'b0;
        issue(v);
        void'(exp_q.pop_front());
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("ws%0d_req", k), {31'h0, imem_req}, 32'h1);
            chk($sformatf("ws%0d_addr", k), imem_addr, 32'h10);
            chk($sformatf("ws%0d_valid", k), {31'h0, instr_valid}, 32'h0);
        end
        imem_ready = 1'b1;
        @(negedge clk);
        chk("ws_valid", {31'h0, instr_valid}, 32'h1);
        chk("ws_instr", instr, 32'h10 ^ KEY);

        // Stall holds everything, even with a branch requested.
        hold_pc = pc_out;
        hold_instr = instr;
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_offset = 32'h0000_0100;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("st%0d_pc", k), pc_out, hold_pc);
            chk($sformatf("st%0d_instr", k), instr, hold_instr);
            chk($sformatf("st%0d_valid", k), {31'h0, instr_valid}, 32'h1);
            chk($sformatf("st%0d_req", k), {31'h0, imem_req}, 32'h0);
        end
        clear_ctrl();
        v = '{1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, hold_pc + 32'd4};
        issue(v);
        fetch_one("unstall");

        // Misaligned jr halts, jr wins over jump.
        hold_pc = pc_out;
        jr = 1'b1;
        jr_target = 32'h0000_0202;
        jump = 1'b1;
        @(posedge clk);
        #1;
        clear_ctrl();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("halt%0d_err", k), {31'h0, misaligned_err}, 32'h1);
            chk($sformatf("halt%0d_req", k), {31'h0, imem_req}, 32'h0);
            chk($sformatf("halt%0d_valid", k), {31'h0, instr_valid}, 32'h0);
            chk($sformatf("halt%0d_pc", k), pc_out, hold_pc);
        end

        // Reset, then reset again in the middle of a stalled fetch.
        rst_n = 1'b0;
        @(negedge clk);
        chk("rr_err", {31'h0, misaligned_err}, 32'h0);
        imem_ready = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_req", {31'h0, imem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_req", {31'h0, imem_req}, 32'h0);
        chk("async_pc", pc_out, 32'h0);
        chk("async_valid", {31'h0, instr_valid}, 32'h0);
        @(negedge clk);
        imem_ready = 1'b1;
        rst_n = 1'b1;
        exp_q.push_back(32'h0);
        fetch_one("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
